// File: rtl/i2c_reg_bank.sv
// Application-side register bank for the I2C slave: eight config registers,
// a free-running timestamp with atomic two-byte read, status change interrupts and an ID.
module i2c_reg_bank #(
  parameter logic [7:0]  CHIP_ID   = 8'hA5,
  parameter logic [63:0] CFG_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rw,
  input  logic [7:0]  addr,
  input  logic        wen,
  input  logic [7:0]  wdata,
  input  logic        rdata_used,
  output logic [7:0]  rdata,
  input  logic [7:0]  status_i,
  output logic [63:0] cfg,
  output logic        irq
);

  localparam logic [7:0] ADDR_TS_LO = 8'h08;
  localparam logic [7:0] ADDR_TS_HI = 8'h09;
  localparam logic [7:0] ADDR_CTRL  = 8'h0A;
  localparam logic [7:0] ADDR_STAT  = 8'h0B;
  localparam logic [7:0] ADDR_MASK  = 8'h0C;
  localparam logic [7:0] ADDR_PEND  = 8'h0D;
  localparam logic [7:0] ADDR_ID    = 8'h0F;

  logic [15:0] ts;
  logic        ts_en;
  logic [7:0]  ts_hold;
  logic [7:0]  ts_shadow;
  logic [7:0]  status_q;
  logic [7:0]  irq_mask;
  logic [7:0]  pending;
  logic [7:0]  rd_next;
  logic [7:0]  pend_set;
  logic [7:0]  pend_clr;

  logic wr_cfg;
  logic wr_ctrl;
  logic wr_mask;
  logic wr_pend;
  logic ts_lo_sel;

  // The slave's direction flag carries no information the decode needs.
  logic unused_rw;
  assign unused_rw = rw;

  assign wr_cfg    = wen && (addr[7:3] == 5'd0);
  assign wr_ctrl   = wen && (addr == ADDR_CTRL);
  assign wr_mask   = wen && (addr == ADDR_MASK);
  assign wr_pend   = wen && (addr == ADDR_PEND);
  assign ts_lo_sel = (addr == ADDR_TS_LO);

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg <= CFG_RESET;
    end else if (wr_cfg) begin
      cfg[{addr[2:0], 3'b000} +: 8] <= wdata;
    end
  end

  // Clear has priority over counting; the enable bit lands in the same write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts    <= 16'h0000;
      ts_en <= 1'b1;
    end else begin
      if (wr_ctrl) begin
        ts_en <= wdata[0];
      end
      if (wr_ctrl && wdata[1]) begin
        ts <= 16'h0000;
      end else if (ts_en) begin
        ts <= ts + 16'd1;
      end
    end
  end

  // ts_hold is captured alongside the low byte, so the shadow pairs with the byte actually sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_hold   <= 8'h00;
      ts_shadow <= 8'h00;
    end else begin
      if (ts_lo_sel) begin
        ts_hold <= ts[15:8];
      end
      if (ts_lo_sel && rdata_used) begin
        ts_shadow <= ts_hold;
      end
    end
  end

  assign pend_set = status_q ^ status_i;
  assign pend_clr = wr_pend ? wdata : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 8'h00;
      irq_mask <= 8'h00;
      pending  <= 8'h00;
      irq      <= 1'b0;
    end else begin
      status_q <= status_i;
      if (wr_mask) begin
        irq_mask <= wdata;
      end
      pending <= (pending & ~pend_clr) | pend_set;
      irq     <= |(pending & irq_mask);
    end
  end

  always_comb begin
    rd_next = 8'h00;
    case (addr)
      8'h00, 8'h01, 8'h02, 8'h03,
      8'h04, 8'h05, 8'h06, 8'h07: rd_next = cfg[{addr[2:0], 3'b000} +: 8];
      ADDR_TS_LO:                 rd_next = ts[7:0];
      ADDR_TS_HI:                 rd_next = ts_shadow;
      ADDR_CTRL:                  rd_next = {7'd0, ts_en};
      ADDR_STAT:                  rd_next = status_q;
      ADDR_MASK:                  rd_next = irq_mask;
      ADDR_PEND:                  rd_next = pending;
      ADDR_ID:                    rd_next = CHIP_ID;
      default:                    rd_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 8'h00;
    end else begin
      rdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Scoreboard bench for i2c_reg_bank: stimulus queues expected outputs, a negedge monitor compares them.
module tb_i2c_reg_bank;

  localparam logic [63:0] CFG_R = 64'h8877665544332211;

  localparam int SEL_RDATA = 0;
  localparam int SEL_CFG   = 1;
  localparam int SEL_IRQ   = 2;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rw;
  logic [7:0]  addr;
  logic        wen;
  logic [7:0]  wdata;
  logic        rdata_used;
  logic [7:0]  rdata;
  logic [7:0]  status_i;
  logic [63:0] cfg;
  logic        irq;

  exp_t exp_q[$];
  int   tests_run;
  int   tests_failed;

  i2c_reg_bank #(
    .CHIP_ID  (8'hA5),
    .CFG_RESET(CFG_R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rw        (rw),
    .addr      (addr),
    .wen       (wen),
    .wdata     (wdata),
    .rdata_used(rdata_used),
    .rdata     (rdata),
    .status_i  (status_i),
    .cfg       (cfg),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one bus cycle; strobes are single-cycle and drop after the edge.
  task automatic applyStimulus(input logic [7:0] a, input logic w, input logic [7:0] d,
                               input logic used);
    addr       = a;
    wen        = w;
    wdata      = d;
    rdata_used = used;
    tick();
    wen        = 1'b0;
    rdata_used = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [63:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are stable mid-cycle, so every queued expectation is settled at the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e = exp_q.pop_front();
      case (e.sel)
        SEL_RDATA: act = {56'd0, rdata};
        SEL_CFG:   act = cfg;
        default:   act = {63'd0, irq};
      endcase
      tests_run++;
      if (act !== e.exp) begin
        tests_failed++;
        $display("[TB] FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    rw         = 1'b0;
    addr       = 8'h00;
    wen        = 1'b0;
    wdata      = 8'h00;
    rdata_used = 1'b0;
    status_i   = 8'h00;

    tick();
    tick();
    checkOutput("reset_rdata", SEL_RDATA, 64'h00);
    checkOutput("reset_cfg", SEL_CFG, CFG_R);
    checkOutput("reset_irq", SEL_IRQ, 64'h0);
    rst = 1'b0;

    applyStimulus(8'h0F, 1'b0, 8'h00, 1'b0);
    checkOutput("id_read", SEL_RDATA, 64'hA5);
    applyStimulus(8'h0A, 1'b0, 8'h00, 1'b0);
    checkOutput("ctrl_reset", SEL_RDATA, 64'h01);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("cfg0_reset", SEL_RDATA, 64'h11);

    // Burst write then sweep readback.
    rw = 1'b0;
    applyStimulus(8'h02, 1'b1, 8'h11, 1'b0);
    applyStimulus(8'h03, 1'b1, 8'h22, 1'b0);
    applyStimulus(8'h04, 1'b1, 8'h33, 1'b0);
    checkOutput("burst_cfg", SEL_CFG, 64'h8877663322112211);
    rw = 1'b1;
    applyStimulus(8'h02, 1'b0, 8'h00, 1'b0);
    checkOutput("read_cfg2", SEL_RDATA, 64'h11);
    applyStimulus(8'h03, 1'b0, 8'h00, 1'b0);
    checkOutput("read_cfg3", SEL_RDATA, 64'h22);
    applyStimulus(8'h04, 1'b0, 8'h00, 1'b0);
    checkOutput("read_cfg4", SEL_RDATA, 64'h33);
    applyStimulus(8'h05, 1'b1, 8'hAB, 1'b0);
    checkOutput("write_edge_old", SEL_RDATA, 64'h66);
    tick();
    checkOutput("write_then_read", SEL_RDATA, 64'hAB);

    // Atomic timestamp: clear, count to 0x1300, capture low byte 0xFF, high byte must be 0x12.
    applyStimulus(8'h0A, 1'b1, 8'h03, 1'b0);
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b0);
    repeat (16'h1300 - 1) tick();
    checkOutput("ts_lo_ff", SEL_RDATA, 64'hFF);
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'h09, 1'b0, 8'h00, 1'b0);
    checkOutput("ts_hi_atomic", SEL_RDATA, 64'h12);

    // Timestamp control: freeze, clear-and-run, wrap.
    applyStimulus(8'h0A, 1'b1, 8'h02, 1'b0);
    applyStimulus(8'h0A, 1'b0, 8'h00, 1'b0);
    checkOutput("ctrl_en_off", SEL_RDATA, 64'h00);
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b0);
    repeat (4) tick();
    checkOutput("ts_frozen", SEL_RDATA, 64'h00);
    applyStimulus(8'h0A, 1'b1, 8'h00, 1'b0);
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    checkOutput("ts_frozen_w0", SEL_RDATA, 64'h00);
    applyStimulus(8'h0A, 1'b1, 8'h03, 1'b0);
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b0);
    checkOutput("ts_clr_0", SEL_RDATA, 64'h00);
    tick();
    checkOutput("ts_run_1", SEL_RDATA, 64'h01);
    tick();
    checkOutput("ts_run_2", SEL_RDATA, 64'h02);
    repeat (32'h10000 - 3) tick();
    checkOutput("ts_lo_pre_wrap", SEL_RDATA, 64'hFF);
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b1);
    checkOutput("ts_lo_wrap", SEL_RDATA, 64'h00);
    applyStimulus(8'h09, 1'b0, 8'h00, 1'b0);
    checkOutput("ts_hi_pre_wrap", SEL_RDATA, 64'hFF);
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b0);
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'h09, 1'b0, 8'h00, 1'b0);
    checkOutput("ts_hi_wrapped", SEL_RDATA, 64'h00);

    // Interrupts.
    applyStimulus(8'h0C, 1'b1, 8'h01, 1'b0);
    status_i = 8'h02;
    tick();
    tick();
    checkOutput("irq_masked_bit", SEL_IRQ, 64'h0);
    applyStimulus(8'h0D, 1'b0, 8'h00, 1'b0);
    checkOutput("pend_bit1", SEL_RDATA, 64'h02);
    status_i = 8'h03;
    tick();
    checkOutput("irq_n1", SEL_IRQ, 64'h0);
    tick();
    checkOutput("irq_n2", SEL_IRQ, 64'h1);
    checkOutput("pend_both", SEL_RDATA, 64'h03);
    applyStimulus(8'h0B, 1'b0, 8'h00, 1'b0);
    checkOutput("status_read", SEL_RDATA, 64'h03);
    status_i = 8'h02;
    applyStimulus(8'h0D, 1'b1, 8'h01, 1'b0);
    tick();
    checkOutput("set_wins_pend", SEL_RDATA, 64'h03);
    checkOutput("set_wins_irq", SEL_IRQ, 64'h1);
    applyStimulus(8'h0D, 1'b1, 8'h01, 1'b0);
    checkOutput("w1c_irq_n1", SEL_IRQ, 64'h1);
    tick();
    checkOutput("w1c_irq_n2", SEL_IRQ, 64'h0);
    checkOutput("w1c_pend", SEL_RDATA, 64'h02);
    applyStimulus(8'h0D, 1'b1, 8'h02, 1'b0);
    tick();
    checkOutput("w1c_all", SEL_RDATA, 64'h00);

    // Unmapped and read-only writes are ignored.
    applyStimulus(8'h0E, 1'b1, 8'h55, 1'b0);
    applyStimulus(8'h80, 1'b1, 8'h55, 1'b0);
    applyStimulus(8'h0F, 1'b1, 8'h55, 1'b0);
    checkOutput("unmapped_cfg", SEL_CFG, 64'h8877AB3322112211);
    checkOutput("id_ro", SEL_RDATA, 64'hA5);
    applyStimulus(8'h0E, 1'b0, 8'h00, 1'b0);
    checkOutput("read_0e", SEL_RDATA, 64'h00);
    applyStimulus(8'h80, 1'b0, 8'h00, 1'b0);
    checkOutput("read_80", SEL_RDATA, 64'h00);
    applyStimulus(8'h0C, 1'b0, 8'h00, 1'b0);
    checkOutput("mask_kept", SEL_RDATA, 64'h01);

    // Reset in the middle of a burst.
    status_i = 8'h03;
    tick();
    tick();
    checkOutput("irq_before_rst", SEL_IRQ, 64'h1);
    applyStimulus(8'h01, 1'b1, 8'hEE, 1'b0);
    checkOutput("burst_pre_rst", SEL_CFG, 64'h8877AB332211EE11);
    rst = 1'b1;
    applyStimulus(8'h02, 1'b1, 8'hEF, 1'b0);
    checkOutput("rst_cfg", SEL_CFG, CFG_R);
    checkOutput("rst_rdata", SEL_RDATA, 64'h00);
    checkOutput("rst_irq", SEL_IRQ, 64'h0);
    rst = 1'b0;
    applyStimulus(8'h0A, 1'b0, 8'h00, 1'b0);
    checkOutput("rst_ctrl", SEL_RDATA, 64'h01);
    applyStimulus(8'h02, 1'b0, 8'h00, 1'b0);
    checkOutput("rst_wen_ignored", SEL_RDATA, 64'h33);
    applyStimulus(8'h0C, 1'b0, 8'h00, 1'b0);
    checkOutput("rst_mask", SEL_RDATA, 64'h00);

    tick();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
